// File: rtl/servo_pkg.sv
// Shared helpers for the multi-channel servo PWM block: timing constants
// derived from clock/frame/pulse parameters, and the per-frame slew step.
package servo_pkg;

    function automatic int calc_tick_div(longint clk_hz, int pos_w, int min_us, int max_us);
        return int'((clk_hz * longint'(max_us - min_us)) /
                    (longint'(1000000) * (longint'(1) << pos_w)));
    endfunction

    function automatic int calc_frame_ticks(int frame_hz, int pos_w, int min_us, int max_us);
        return int'((longint'(1000000 / frame_hz) * (longint'(1) << pos_w)) /
                    longint'(max_us - min_us));
    endfunction

    function automatic int calc_min_ticks(int pos_w, int min_us, int max_us);
        return int'((longint'(min_us) * (longint'(1) << pos_w)) / longint'(max_us - min_us));
    endfunction

    // Move cur toward tgt by at most step, landing exactly on tgt when close.
    function automatic int slew_step(int cur, int tgt, int step);
        if (tgt > cur)
            return (tgt - cur > step) ? cur + step : tgt;
        else
            return (cur - tgt > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing one tick per TICK_DIV clocks and a frame counter
// that wraps at FRAME_TICKS, flagging the wrap cycle as frame_start.
module servo_tick_gen #(
    parameter int TICK_DIV    = 46,
    parameter int FRAME_TICKS = 5120,
    parameter int CTR_W       = $clog2(FRAME_TICKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             frame_start,
    output logic [CTR_W-1:0] ctr_next
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_reg;
    logic             tick_reg;
    logic             frame_start_reg;
    logic [CTR_W-1:0] frame_ctr_reg;
    logic             div_wrap;

    assign div_wrap = (div_reg == DIV_W'(TICK_DIV - 1));

    // The frame counter only moves on a tick, so its value one cycle before the
    // tick is already final; that lets frame_start be registered yet coincide with the wrapping tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg         <= '0;
            tick_reg        <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_ctr_reg   <= '0;
        end else begin
            div_reg         <= div_wrap ? '0 : div_reg + 1'b1;
            tick_reg        <= div_wrap;
            frame_start_reg <= div_wrap && (frame_ctr_reg == CTR_W'(FRAME_TICKS - 1));
            frame_ctr_reg   <= ctr_next;
        end
    end

    assign ctr_next    = frame_start_reg ? '0 : frame_ctr_reg + CTR_W'(tick_reg);
    assign frame_start = frame_start_reg;

endmodule

// File: rtl/servo_multi.sv
// N-channel servo PWM generator with frame-aligned shadow commits.
// Define SERVO_SLEW_EN to limit position change to SLEW_STEP per frame.
module servo_multi
    import servo_pkg::*;
#(
    parameter int CLK_FREQUENCY = 12000000,
    parameter int NUM_CH        = 4,
    parameter int POS_W         = 8,
    parameter int FRAME_HZ      = 50,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int RESET_POS     = 2 ** (POS_W - 1),
    parameter int SLEW_STEP     = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         wr_valid,
    output logic                                         wr_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
    input  logic [POS_W-1:0]                             wr_pos,
    output logic                                         wr_err,
    input  logic [NUM_CH-1:0]                            ch_en,
    output logic                                         frame_sync,
    output logic [NUM_CH-1:0]                            pwm
);

    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TICK_DIV    = calc_tick_div(longint'(CLK_FREQUENCY), POS_W, MIN_US, MAX_US);
    localparam int FRAME_TICKS = calc_frame_ticks(FRAME_HZ, POS_W, MIN_US, MAX_US);
    localparam int MIN_TICKS   = calc_min_ticks(POS_W, MIN_US, MAX_US);
    localparam int CTR_W       = $clog2(FRAME_TICKS);
    localparam int CMP_W       = CTR_W + 1;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("servo_multi: TICK_DIV must be at least 2");
    end
    if (MIN_TICKS + 2 ** POS_W > FRAME_TICKS) begin : g_bad_frame
        $error("servo_multi: maximum pulse does not fit inside the frame");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("servo_multi: NUM_CH must be 1..16");
    end
    if (SLEW_STEP < 1) begin : g_bad_slew
        $error("servo_multi: SLEW_STEP must be positive");
    end

    logic             frame_start;
    logic [CTR_W-1:0] ctr_next;
    logic             wr_ready_reg;
    logic             wr_err_reg;
    logic             wr_fire;

    servo_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .FRAME_TICKS(FRAME_TICKS),
        .CTR_W      (CTR_W)
    ) u_tick_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .ctr_next   (ctr_next)
    );

    assign wr_fire = wr_valid && wr_ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ready_reg <= 1'b0;
            wr_err_reg   <= 1'b0;
        end else begin
            wr_ready_reg <= 1'b1;
            wr_err_reg   <= wr_fire && ({1'b0, wr_ch} >= (CH_W + 1)'(NUM_CH));
        end
    end

    assign wr_ready   = wr_ready_reg;
    assign wr_err     = wr_err_reg;
    assign frame_sync = frame_start;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [POS_W-1:0] shadow_reg;
        logic [POS_W-1:0] target_reg;
        logic [POS_W-1:0] target_next;
        logic [POS_W-1:0] cur_next;
        logic             en_q_reg;
        logic             en_next;
        logic             pwm_reg;

        assign target_next = frame_start ? shadow_reg : target_reg;
        assign en_next     = frame_start ? ch_en[gi] : en_q_reg;

`ifdef SERVO_SLEW_EN
        logic [POS_W-1:0] cur_reg;

        assign cur_next = frame_start
                        ? POS_W'(slew_step(int'(cur_reg), int'(target_next), SLEW_STEP))
                        : cur_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                cur_reg <= POS_W'(RESET_POS);
            else
                cur_reg <= cur_next;
        end
`else
        // Without slew limiting cur always equals target, so target doubles as cur.
        assign cur_next = target_next;
`endif

        // pwm is computed from next-state values so it lines up with the frame
        // counter: high from the clock after frame_start for (MIN_TICKS+cur) ticks.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg <= POS_W'(RESET_POS);
                target_reg <= POS_W'(RESET_POS);
                en_q_reg   <= 1'b0;
                pwm_reg    <= 1'b0;
            end else begin
                if (wr_fire && (wr_ch == CH_W'(gi)))
                    shadow_reg <= wr_pos;
                target_reg <= target_next;
                en_q_reg   <= en_next;
                pwm_reg    <= en_next &&
                              (CMP_W'(ctr_next) < CMP_W'(MIN_TICKS) + CMP_W'(cur_next));
            end
        end

        assign pwm[gi] = pwm_reg;
    end

endmodule
